dev_int_ctrl: RTL and testbench
===============================

// Module: dev_int_ctrl
// PURPOSE
//  Device interrupt controller feeding the CPU control unit's pic_in/pic_read pair.
//  It samples the five device CSRs (kb, scr, tmr, tl, pb) on every clock and latches
//  interrupt requests on DBA rising edges while IE is set.
//  It arbitrates by per-device priority against the CPU current priority (PSW[7:5])
//  and offers one vector at a time, holding it until the CPU acknowledges.
// PARAMETERS
//  NUM_DEV    5                 number of device sources; index 0..4 = kb,scr,tmr,tl,pb
//  DEV_PRI    15'o76543         packed 3b priority per device; dev i = DEV_PRI[3i+2:3i]
//  VECT_BASE  4'd8              vector number of dev 0; dev i -> VECT_BASE+i (mod 16)
// PORTS
//  Clock         in   1   system clock; all state updates on posedge
//  Reset         in   1   synchronous, active-high
//  csr_kb        in   8   kb CSR: [0]=IE [1]=I/O [2]=DBA [3]=OF
//  csr_scr       in   8   scr CSR, same layout
//  csr_tmr       in   8   tmr CSR, same layout
//  csr_tl        in   8   tl CSR, same layout
//  csr_pb        in   8   pb CSR, same layout
//  cur_pri       in   3   CPU current priority (PSW[7:5])
//  pic_read      in   1   CPU acknowledge; one-cycle pulse while an offer is valid
//  pic_in        out  8   offer: [7]=valid [6:4]=priority [3:0]=vector number
//  irq_pending   out  5   pending request bit per device
//  spurious_ack  out  1   sticky: pic_read seen with no valid offer
// BEHAVIOUR
//  Reset (one cycle is enough; any state, including mid-offer):
//   - pic_in=8'h00, irq_pending=0, spurious_ack=0, state=IDLE.
//   - Edge-detect history is loaded from the current req_i, so levels already high do not fire.
//  Request detect:
//   - req_i = csr_i[2] & csr_i[0].
//   - pending[i] sets on a 0->1 transition of req_i between consecutive clocks.
//   - IE falling clears pending[i], except for the device currently offered.
//   - A simultaneous set and ack-clear on the same device: set wins.
//  Eligibility:
//   - Dev i is eligible when pending[i] && pri_i > cur_pri.
//   - Winner = highest pri_i among eligible devices; ties go to the lowest index.
//  FSM (2b state):
//   - IDLE -> ARB when any device is eligible.
//   - ARB: register winner index, pri and vector; -> OFFER.
//   - OFFER: pic_in = {1,pri,vect}, held stable every cycle.
//      - A higher-priority arrival does NOT replace the offer.
//      - pic_read=1: clear pending[winner]; pic_in[7]=0 from next cycle; -> IDLE.
//      - cur_pri >= offered pri (and no pic_read): withdraw. pic_in[7]=0 next cycle;
//        pending stays set; -> IDLE.
//      - If pic_read and withdraw coincide, the ack wins.
//   - Latency: DBA edge sampled at edge N -> pending at N -> ARB at N+1 -> pic_in valid at N+2.
//   - After an ack, the next offer is valid no earlier than 2 cycles later (IDLE, ARB).
//  Other rules:
//   - pic_read outside OFFER: ignored for state; sets spurious_ack until Reset.
//   - Vector arithmetic is 4-bit modulo; priorities compare unsigned.
//   - Priority 0 devices can never win (cur_pri >= 0 always).
//   - pic_in[6:0] = 0 whenever pic_in[7] = 0.
// STRUCTURE
//  Shared package/defines (dev_defs.vh):
//   - Device indices KB=0,SCR=1,TMR=2,TL=3,PB=4.
//   - CSR bit positions IE=0, IO=1, DBA=2, OF=3.
//   - FSM encodings IDLE=0, ARB=1, OFFER=2.
//   - Also used by the CPU top-level device map.
//  One sub-module, pri_arbiter: combinational; {pending, DEV_PRI, cur_pri} ->
//  {any_eligible, win_idx[2:0], win_pri[2:0]}. All registers stay in dev_int_ctrl.
// TESTING
//  1 Reset; csr_tmr 8'h01 -> 8'h05, cur_pri=0
//    -> irq_pending=5'b00100 at N; pic_in=8'hDA (pri5, vect 10) at N+2.
//  2 kb (pri3) and pb (pri7) DBA rise in the same cycle, cur_pri=2
//    -> pb offered first (8'hFC); pic_read -> kb offered 2 cycles later (8'hB8).
//  3 While tl is offered (pri6), raise cur_pri to 6
//    -> pic_in[7]=0 next cycle, irq_pending[3] stays 1; lower cur_pri to 0 -> re-offered.
//  4 csr_scr held at 8'h05 through Reset release -> no pending.
//    Pulse DBA low then high -> pending set; pic_read while IDLE -> spurious_ack=1.
//  5 Assert Reset during OFFER with pic_read=1
//    -> next cycle pic_in=8'h00, irq_pending=0, spurious_ack=0.
//  6 Offered kb gets a new DBA edge in the same cycle as pic_read
//    -> pending[0] remains 1 and kb is re-offered after 2 cycles.

Source files
------------

// File: rtl/dev_int_ctrl_pkg.sv
// Shared definitions for the device interrupt controller: device indices,
// CSR bit positions, FSM encoding and the vector helper.
package dev_int_ctrl_pkg;

    localparam int          NUM_DEV_DEF   = 5;
    localparam logic [14:0] DEV_PRI_DEF   = 15'o76543;
    localparam logic [3:0]  VECT_BASE_DEF = 4'd8;

    typedef enum int {
        DEV_KB  = 0,
        DEV_SCR = 1,
        DEV_TMR = 2,
        DEV_TL  = 3,
        DEV_PB  = 4
    } dev_e;

    typedef enum int {
        CSR_IE  = 0,
        CSR_IO  = 1,
        CSR_DBA = 2,
        CSR_OF  = 3
    } csr_bit_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_OFFER = 2'd2
    } state_e;

    // Vector numbers wrap modulo 16.
    function automatic logic [3:0] dev_vector(input logic [3:0] base, input logic [2:0] idx);
        return base + {1'b0, idx};
    endfunction

endpackage

// File: rtl/dev_int_ctrl_pri_arbiter.sv
// Combinational priority arbiter: highest priority above cur_pri wins,
// ties resolved toward the lowest device index.
module dev_int_ctrl_pri_arbiter
    import dev_int_ctrl_pkg::*;
#(
    parameter int                     NUM_DEV = NUM_DEV_DEF,
    parameter logic [3*NUM_DEV-1:0]   DEV_PRI = DEV_PRI_DEF
) (
    input  logic [NUM_DEV-1:0] pending_i,
    input  logic [2:0]         cur_pri_i,
    output logic               any_elig_o,
    output logic [2:0]         win_idx_o,
    output logic [2:0]         win_pri_o
);

    logic [2:0] pri;

    always_comb begin
        any_elig_o = 1'b0;
        win_idx_o  = '0;
        win_pri_o  = '0;
        pri        = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            pri = DEV_PRI[3*i +: 3];
            // Strict '>' against the running best keeps the lowest index on ties.
            if (pending_i[i] && (pri > cur_pri_i) && (!any_elig_o || (pri > win_pri_o))) begin
                any_elig_o = 1'b1;
                win_idx_o  = 3'(i);
                win_pri_o  = pri;
            end
        end
    end

endmodule

// File: rtl/dev_int_ctrl.sv
// Device interrupt controller: edge-detects device requests, arbitrates them
// against the CPU priority and holds one vector offer until acknowledged.
module dev_int_ctrl
    import dev_int_ctrl_pkg::*;
#(
    parameter int                   NUM_DEV   = NUM_DEV_DEF,
    parameter logic [3*NUM_DEV-1:0] DEV_PRI   = DEV_PRI_DEF,
    parameter logic [3:0]           VECT_BASE = VECT_BASE_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         csr_kb_i,
    input  logic [7:0]         csr_scr_i,
    input  logic [7:0]         csr_tmr_i,
    input  logic [7:0]         csr_tl_i,
    input  logic [7:0]         csr_pb_i,
    input  logic [2:0]         cur_pri_i,
    input  logic               pic_read_i,
    output logic [7:0]         pic_in_o,
    output logic [NUM_DEV-1:0] irq_pending_o,
    output logic               spurious_ack_o
);

    logic [7:0]         csr [NUM_DEV];
    logic [NUM_DEV-1:0] req, ie, rise, ie_fall;
    logic [NUM_DEV-1:0] req_q, ie_q;
    logic [NUM_DEV-1:0] pending_q, pending_d;
    logic               spurious_q, spurious_d;
    state_e             state_q, state_d;
    logic               load_offer;
    logic               any_elig;
    logic [2:0]         arb_idx, arb_pri;
    logic [2:0]         win_idx_q, win_pri_q;
    logic [3:0]         win_vect_q;
    logic               unused_csr_bits;

    assign csr[DEV_KB]  = csr_kb_i;
    assign csr[DEV_SCR] = csr_scr_i;
    assign csr[DEV_TMR] = csr_tmr_i;
    assign csr[DEV_TL]  = csr_tl_i;
    assign csr[DEV_PB]  = csr_pb_i;

    assign unused_csr_bits = ^{csr_kb_i[7:3], csr_kb_i[1], csr_scr_i[7:3], csr_scr_i[1],
                               csr_tmr_i[7:3], csr_tmr_i[1], csr_tl_i[7:3], csr_tl_i[1],
                               csr_pb_i[7:3], csr_pb_i[1]};

    always_comb begin
        ie  = '0;
        req = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            ie[i]  = csr[i][CSR_IE];
            req[i] = csr[i][CSR_DBA] & csr[i][CSR_IE];
        end
    end

    assign rise    = req & ~req_q;
    assign ie_fall = ie_q & ~ie;

    dev_int_ctrl_pri_arbiter #(
        .NUM_DEV (NUM_DEV),
        .DEV_PRI (DEV_PRI)
    ) u_arb (
        .pending_i  (pending_q),
        .cur_pri_i  (cur_pri_i),
        .any_elig_o (any_elig),
        .win_idx_o  (arb_idx),
        .win_pri_o  (arb_pri)
    );

    always_comb begin
        state_d    = state_q;
        load_offer = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_elig) state_d = ST_ARB;
            end
            ST_ARB: begin
                // Eligibility can vanish during ARB if cur_pri rose; fall back to IDLE.
                if (any_elig) begin
                    load_offer = 1'b1;
                    state_d    = ST_OFFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (pic_read_i || (cur_pri_i >= win_pri_q)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_DEV; i++) begin
            // A new edge always wins over an ack or IE-fall clear on the same device.
            pending_d[i] = rise[i] | (pending_q[i] &
                ~(((state_q == ST_OFFER) && (win_idx_q == 3'(i)) && pic_read_i) ||
                  (ie_fall[i] && !((state_q == ST_OFFER) && (win_idx_q == 3'(i))))));
        end
        spurious_d = spurious_q | (pic_read_i && (state_q != ST_OFFER));
    end

    always_ff @(posedge clk_i) begin
        req_q <= req;
        ie_q  <= ie;
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            spurious_q <= spurious_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_offer) begin
            win_idx_q  <= arb_idx;
            win_pri_q  <= arb_pri;
            win_vect_q <= dev_vector(VECT_BASE, arb_idx);
        end
    end

    assign pic_in_o       = (state_q == ST_OFFER) ? {1'b1, win_pri_q, win_vect_q} : 8'h00;
    assign irq_pending_o  = pending_q;
    assign spurious_ack_o = spurious_q;

endmodule

// File: tb/tb_dev_int_ctrl.sv
// Bench for dev_int_ctrl: directed scenarios with literal expectations plus
// randomized CSR/priority/ack traffic checked every cycle against a reference model.
module tb_dev_int_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] csr [5];
    logic [2:0] cur = 3'd0;
    logic       rd  = 1'b0;
    logic [7:0] pic_in;
    logic [4:0] irq_pend;
    logic       spur;

    dev_int_ctrl u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .csr_kb_i       (csr[0]),
        .csr_scr_i      (csr[1]),
        .csr_tmr_i      (csr[2]),
        .csr_tl_i       (csr[3]),
        .csr_pb_i       (csr[4]),
        .cur_pri_i      (cur),
        .pic_read_i     (rd),
        .pic_in_o       (pic_in),
        .irq_pending_o  (irq_pend),
        .spurious_ack_o (spur)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int PRI [5]  = '{3, 4, 5, 6, 7};

    // Model state: phase 0 = nothing offered, 1 = choosing, 2 = offering m_dev.
    bit [4:0]   m_pend  = '0;
    int         m_phase = 0;
    int         m_dev   = 0;
    bit         m_spur  = 1'b0;
    bit [4:0]   m_req_h = '0;
    bit [4:0]   m_ie_h  = '0;
    bit         cmp_en  = 1'b0;
    logic [7:0] exp_pic;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int pick(input bit [4:0] p, input int c);
        int best;
        best = -1;
        for (int i = 0; i < 5; i++)
            if (p[i] && PRI[i] > c && (best < 0 || PRI[i] > PRI[best])) best = i;
        return best;
    endfunction

    task automatic tick();
        bit [4:0] rq, ie_now, np;
        int       nphase, ndev, w;
        bit       nspur, ack, keep;
        for (int i = 0; i < 5; i++) begin
            ie_now[i] = csr[i][0];
            rq[i]     = csr[i][0] & csr[i][2];
        end
        nphase = m_phase;
        ndev   = m_dev;
        if (rst) begin
            np     = '0;
            nphase = 0;
            nspur  = 1'b0;
        end else begin
            ack   = (m_phase == 2) && rd;
            nspur = m_spur | (rd && m_phase != 2);
            for (int i = 0; i < 5; i++) begin
                keep = m_pend[i];
                if (ack && m_dev == i) keep = 1'b0;
                if (m_ie_h[i] && !ie_now[i] && !(m_phase == 2 && m_dev == i)) keep = 1'b0;
                np[i] = keep | (rq[i] & ~m_req_h[i]);
            end
            w = pick(m_pend, int'(cur));
            case (m_phase)
                0: if (w >= 0) nphase = 1;
                1: if (w >= 0) begin nphase = 2; ndev = w; end else nphase = 0;
                default: if (ack || int'(cur) >= PRI[m_dev]) nphase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        m_pend  = np;
        m_phase = nphase;
        m_dev   = ndev;
        m_spur  = nspur;
        m_req_h = rq;
        m_ie_h  = ie_now;
        cmp_en  = 1'b1;
    endtask

    task automatic clear_and_reset();
        for (int i = 0; i < 5; i++) csr[i] = 8'h00;
        cur = 3'd0;
        rd  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_pic = (m_phase == 2) ? {1'b1, 3'(PRI[m_dev]), 4'(8 + m_dev)} : 8'h00;
            chk("pic_in", int'(pic_in), int'(exp_pic));
            chk("irq_pending", int'(irq_pend), int'(m_pend));
            chk("spurious_ack", int'(spur), int'(m_spur));
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) csr[i] = 8'h00;

        // 1: tmr edge -> pending at N, 8'hDA at N+2
        csr[2] = 8'h01;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t1_reset_pic", int'(pic_in), 'h00);
        chk("t1_reset_pend", int'(irq_pend), 'h00);
        tick();
        csr[2] = 8'h05; tick();
        chk("t1_pend_N", int'(irq_pend), 'b00100);
        chk("t1_pic_N", int'(pic_in), 'h00);
        tick();
        chk("t1_pic_N1", int'(pic_in), 'h00);
        tick();
        chk("t1_pic_N2", int'(pic_in), 'hDA);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("t1_ack_pic", int'(pic_in), 'h00);
        chk("t1_ack_pend", int'(irq_pend), 'h00);

        // 2: kb and pb together, cur_pri 2 -> pb first, then kb
        clear_and_reset();
        cur = 3'd2; csr[0] = 8'h01; csr[4] = 8'h01; tick();
        csr[0] = 8'h05; csr[4] = 8'h05; tick();
        chk("t2_pend", int'(irq_pend), 'b10001);
        tick(); tick();
        chk("t2_pb_offer", int'(pic_in), 'hFC);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("t2_after_ack", int'(pic_in), 'h00);
        tick();
        chk("t2_arb_pend", int'(irq_pend), 'b00001);
        tick();
        chk("t2_kb_offer", int'(pic_in), 'hB8);
        rd = 1'b1; tick(); rd = 1'b0;

        // 3: withdraw on cur_pri rise, re-offer after it drops
        clear_and_reset();
        csr[3] = 8'h01; tick();
        csr[3] = 8'h05; tick(); tick(); tick();
        chk("t3_tl_offer", int'(pic_in), 'hEB);
        cur = 3'd6; tick();
        chk("t3_withdrawn", int'(pic_in), 'h00);
        chk("t3_pend_kept", int'(irq_pend[3]), 1);
        cur = 3'd0; tick(); tick();
        chk("t3_reoffer", int'(pic_in), 'hEB);
        rd = 1'b1; tick(); rd = 1'b0;

        // 4: level high through reset does not fire; spurious ack while idle
        for (int i = 0; i < 5; i++) csr[i] = 8'h00;
        csr[1] = 8'h05; cur = 3'd0;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("t4_no_pend", int'(irq_pend), 'h00);
        csr[1] = 8'h01; tick();
        csr[1] = 8'h05; tick();
        chk("t4_pend", int'(irq_pend), 'b00010);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("t4_spurious", int'(spur), 1);
        tick();
        chk("t4_scr_offer", int'(pic_in), 'hC9);
        rd = 1'b1; tick(); rd = 1'b0;

        // 5: reset during an offer with pic_read high
        clear_and_reset();
        csr[2] = 8'h01; tick();
        rd = 1'b1; tick(); rd = 1'b0;
        csr[2] = 8'h05; tick(); tick(); tick();
        chk("t5_offer", int'(pic_in), 'hDA);
        chk("t5_spur_set", int'(spur), 1);
        rst = 1'b1; rd = 1'b1; tick(); rst = 1'b0; rd = 1'b0;
        chk("t5_rst_pic", int'(pic_in), 'h00);
        chk("t5_rst_pend", int'(irq_pend), 'h00);
        chk("t5_rst_spur", int'(spur), 0);

        // 6: new kb edge coincides with the ack of kb
        clear_and_reset();
        csr[0] = 8'h01; tick();
        csr[0] = 8'h05; tick(); tick(); tick();
        chk("t6_offer", int'(pic_in), 'hB8);
        csr[0] = 8'h01; tick();
        chk("t6_held", int'(pic_in), 'hB8);
        csr[0] = 8'h05; rd = 1'b1; tick(); rd = 1'b0;
        chk("t6_pend_kept", int'(irq_pend), 'b00001);
        chk("t6_after_ack", int'(pic_in), 'h00);
        tick(); tick();
        chk("t6_reoffer", int'(pic_in), 'hB8);
        rd = 1'b1; tick(); rd = 1'b0;

        // Randomized traffic
        clear_and_reset();
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom % 400) == 0;
            for (int i = 0; i < 5; i++) begin
                if (($urandom % 8) == 0)  csr[i][2] = ~csr[i][2];
                if (($urandom % 20) == 0) csr[i][0] = ~csr[i][0];
                if (($urandom % 16) == 0) csr[i][7:3] = 5'($urandom);
                csr[i][1] = 1'($urandom);
            end
            if (($urandom % 12) == 0) cur = 3'($urandom % 8);
            rd = (m_phase == 2) ? (($urandom % 4) == 0) : (($urandom % 50) == 0);
            tick();
        end
        rst = 1'b0;
        rd  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
